// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one RAM bus between two masters (0: core memory port, 1: loader /
// debug DMA). A granted request is sequenced through the RAM's two-phase
// protocol: an address-latch strobe, then a single read or write strobe,
// followed by a one-cycle ack carrying registered read data.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req[1:0], we[1:0]     per-master request and write enable
//   addr                  per-master address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata                 per-master write data, master i at [i*32 +: 32]
//   size                  per-master access size, master i at [i*2 +: 2]
//   ack[1:0]              one-hot, one-cycle completion pulse
//   rdata                 read data, non-zero only during the ack of a read
//   grant[1:0]            one-hot bus owner while busy
//   busy                  transaction in progress
//   address_bus, data_size, write_address, write, read,
//   data_bus_out, data_bus_out_enable, data_bus_in   RAM side
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [63:0]             wdata,
  input  logic [3:0]              size,
  output logic [1:0]              ack,
  output logic [31:0]             rdata,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   address_bus,
  output logic [31:0]             data_bus_out,
  output logic                    data_bus_out_enable,
  input  logic [31:0]             data_bus_in,
  output logic [1:0]              data_size,
  output logic                    write_address,
  output logic                    write,
  output logic                    read
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    last_grant_q;
  logic                    sel_q;
  logic                    we_q;
  logic [31:0]             wdata_q;

  logic [1:0]              ack_q;
  logic [31:0]             rdata_q;
  logic [1:0]              grant_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   address_bus_q;
  logic [31:0]             data_bus_out_q;
  logic                    data_bus_out_enable_q;
  logic [1:0]              data_size_q;
  logic                    write_address_q;
  logic                    write_q;
  logic                    read_q;

  logic                    sel_d;
  logic                    we_sel_d;
  logic [ADDR_WIDTH-1:0]   addr_sel_d;
  logic [31:0]             wdata_sel_d;
  logic [1:0]              size_sel_d;

  // A lone requester always wins (~req[0] picks master 1 only when master 0
  // is silent). On a tie, round-robin hands the bus to whoever did not have
  // it last; fixed priority keeps the lone-requester answer, i.e. master 0.
  always_comb begin
    sel_d = ~req[0];
    if ((FIXED_PRIORITY == 0) && (req == 2'b11)) begin
      sel_d = ~last_grant_q;
    end
  end

  assign we_sel_d    = sel_d ? we[1] : we[0];
  assign addr_sel_d  = sel_d ? addr[ADDR_WIDTH +: ADDR_WIDTH] : addr[0 +: ADDR_WIDTH];
  assign wdata_sel_d = sel_d ? wdata[32 +: 32] : wdata[0 +: 32];
  assign size_sel_d  = sel_d ? size[2 +: 2] : size[0 +: 2];

  // All bus outputs are registered: each state's outputs are loaded on the
  // edge that enters it, so strobes never glitch and never overlap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q               <= S_IDLE;
      last_grant_q          <= 1'b1;
      sel_q                 <= 1'b0;
      we_q                  <= 1'b0;
      wdata_q               <= '0;
      ack_q                 <= '0;
      rdata_q               <= '0;
      grant_q               <= '0;
      busy_q                <= 1'b0;
      address_bus_q         <= '0;
      data_bus_out_q        <= '0;
      data_bus_out_enable_q <= 1'b0;
      data_size_q           <= '0;
      write_address_q       <= 1'b0;
      write_q               <= 1'b0;
      read_q                <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            state_q         <= S_ADDR;
            sel_q           <= sel_d;
            last_grant_q    <= sel_d;
            we_q            <= we_sel_d;
            wdata_q         <= wdata_sel_d;
            address_bus_q   <= addr_sel_d;
            data_size_q     <= size_sel_d;
            grant_q         <= sel_d ? 2'b10 : 2'b01;
            busy_q          <= 1'b1;
            write_address_q <= 1'b1;
          end
        end
        S_ADDR: begin
          state_q               <= S_ACCESS;
          write_address_q       <= 1'b0;
          write_q               <= we_q;
          read_q                <= ~we_q;
          data_bus_out_enable_q <= we_q;
          data_bus_out_q        <= we_q ? wdata_q : 32'd0;
        end
        S_ACCESS: begin
          state_q               <= S_DONE;
          write_q               <= 1'b0;
          read_q                <= 1'b0;
          data_bus_out_enable_q <= 1'b0;
          data_bus_out_q        <= '0;
          ack_q                 <= sel_q ? 2'b10 : 2'b01;
          // The RAM drives data_bus_in during the read strobe; capture it here.
          rdata_q               <= we_q ? 32'd0 : data_bus_in;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ack_q   <= '0;
          rdata_q <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack                 = ack_q;
  assign rdata               = rdata_q;
  assign grant               = grant_q;
  assign busy                = busy_q;
  assign address_bus         = address_bus_q;
  assign data_bus_out        = data_bus_out_q;
  assign data_bus_out_enable = data_bus_out_enable_q;
  assign data_size           = data_size_q;
  assign write_address       = write_address_q;
  assign write               = write_q;
  assign read                = read_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: one round-robin and one fixed-priority
// instance, each driven by its own masters, predicted by a transaction-level
// model and checked by a scoreboard monitor.
module tb_mem_bus_arbiter;
  localparam int AW = 32;

  typedef struct {
    bit          m;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    int          pc;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit done_f [2];

  function void chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", id, nm, act, exp);
    end
  endfunction

  for (genvar P = 0; P < 2; P++) begin : g_dut
    logic          reset;
    logic [1:0]    req, we;
    logic [2*AW-1:0] addr;
    logic [63:0]   wdata;
    logic [3:0]    size;
    logic [31:0]   data_bus_in;
    logic [1:0]    ack, grant, data_size;
    logic [31:0]   rdata, dbo;
    logic          busy, dbe, wa, wr, rd;
    logic [AW-1:0] address_bus;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIORITY(P)) dut (
      .clock(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .size(size), .ack(ack), .rdata(rdata), .grant(grant),
      .busy(busy), .address_bus(address_bus), .data_bus_out(dbo),
      .data_bus_out_enable(dbe), .data_bus_in(data_bus_in),
      .data_size(data_size), .write_address(wa), .write(wr), .read(rd)
    );

    txn_t        q[$];
    int          pcyc = 0;
    int          free_at = 0;
    int          last_pc = -100;
    bit          last_m = 1'b0;
    bit          lg = 1'b1;
    bit          rst_seen = 1'b1;
    int          exp_cnt [2];
    int          got_cnt [2];
    bit          ram_fixed = 1'b0;
    logic [31:0] ram_val = 32'd0;
    bit          mon_en = 1'b0;

    // Reference model: on every edge the bus is free and somebody asks,
    // one transaction starts; it occupies the bus for four edges.
    initial forever begin
      @(posedge clk);
      pcyc++;
      rst_seen = reset;
      if (reset) begin
        q.delete();
        lg = 1'b1;
        free_at = pcyc + 1;
        if (pcyc <= last_pc + 2) begin
          exp_cnt[last_m]--;
          last_pc = -100;
        end
      end else if (pcyc >= free_at && req != 2'b00) begin
        txn_t t;
        bit   m;
        if (req == 2'b01)      m = 1'b0;
        else if (req == 2'b10) m = 1'b1;
        else                   m = (P == 1) ? 1'b0 : ~lg;
        t.m  = m;
        t.w  = m ? we[1] : we[0];
        t.a  = m ? addr[2*AW-1:AW] : addr[AW-1:0];
        t.d  = m ? wdata[63:32] : wdata[31:0];
        t.s  = m ? size[3:2] : size[1:0];
        t.pc = pcyc;
        q.push_back(t);
        exp_cnt[m]++;
        lg = m;
        last_m = m;
        last_pc = pcyc;
        free_at = pcyc + 4;
      end
    end

    // RAM read data changes just after each edge and is held until the next.
    initial begin
      data_bus_in = 32'd0;
      forever begin
        @(posedge clk);
        #1;
        data_bus_in = ram_fixed ? ram_val : $urandom;
      end
    end

    // Scoreboard monitor.
    initial begin
      txn_t        cur;
      bit          cur_v = 1'b0;
      logic [31:0] cur_rd = 32'd0;
      logic [1:0]  oh;
      int          ph;
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (rst_seen) cur_v = 1'b0;
          if (!cur_v && q.size() > 0 && q[0].pc == pcyc) begin
            cur = q.pop_front();
            cur_v = 1'b1;
          end
          if (cur_v) begin
            ph = pcyc - cur.pc;
            oh = cur.m ? 2'b10 : 2'b01;
            chk(P, "grant", grant, oh);
            chk(P, "busy", busy, 1);
            chk(P, "address_bus", address_bus, cur.a);
            chk(P, "data_size", data_size, cur.s);
            if (ph == 0) begin
              chk(P, "addr_phase_strobes", {wa, wr, rd, dbe, ack}, 6'b100000);
              chk(P, "addr_phase_data", {rdata, dbo}, 0);
            end else if (ph == 1) begin
              chk(P, "access_strobes", {wa, wr, rd, dbe, ack}, {1'b0, cur.w, ~cur.w, cur.w, 2'b00});
              chk(P, "data_bus_out", dbo, cur.w ? cur.d : 32'd0);
              chk(P, "access_rdata", rdata, 0);
              cur_rd = data_bus_in;
            end else begin
              chk(P, "done_phase", ph, 2);
              chk(P, "done_strobes", {wa, wr, rd, dbe, ack}, {4'b0000, oh});
              chk(P, "done_dbo", dbo, 0);
              chk(P, "rdata", rdata, cur.w ? 32'd0 : cur_rd);
              got_cnt[cur.m]++;
              cur_v = 1'b0;
            end
          end else begin
            chk(P, "idle_ctrl", {ack, grant, busy, wa, wr, rd, dbe}, 0);
            chk(P, "idle_data", {rdata, dbo}, 0);
          end
        end
      end
    end

    task automatic mtxn(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s, input bit drop);
      int n;
      @(negedge clk);
      req[i] = 1'b1;
      we[i] = w;
      addr[i*AW +: AW] = a;
      wdata[i*32 +: 32] = d;
      size[i*2 +: 2] = s;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!grant[i] && n < 300);
      chk(P, $sformatf("m%0d_granted", i), grant[i], 1);
      if (!grant[i]) begin
        req[i] = 1'b0;
        return;
      end
      if (drop) begin
        // Withdrawn and scrambled fields must not affect the granted access.
        req[i] = 1'b0;
        we[i] = ~w;
        addr[i*AW +: AW] = ~a;
        wdata[i*32 +: 32] = ~d;
        size[i*2 +: 2] = ~s;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack[i] && n < 10);
      chk(P, $sformatf("m%0d_ack", i), ack[i], 1);
      req[i] = 1'b0;
    endtask

    initial begin
      int n;
      reset = 1'b1;
      req = 2'b00; we = 2'b00; addr = '0; wdata = '0; size = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(P, "reset_ctrl", {ack, grant, busy, wa, wr, rd, dbe, data_size}, 0);
      chk(P, "reset_addr", address_bus, 0);
      chk(P, "reset_data", {rdata, dbo}, 0);
      reset = 1'b0;
      mon_en = 1'b1;

      // Master 0 word write, then master 1 byte read.
      mtxn(0, 1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0);
      ram_fixed = 1'b1;
      ram_val = 32'h000000AB;
      mtxn(1, 1'b0, 32'h104, 32'h0, 2'b00, 1'b0);
      ram_fixed = 1'b0;
      repeat (2) @(negedge clk);

      // Both masters contend, each dropping on its own ack.
      fork
        mtxn(0, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0);
        mtxn(1, 1'b1, 32'h300, 32'hCAFEF00D, 2'b01, 1'b0);
      join
      repeat (2) @(negedge clk);

      // Both requests held high for 20 edges.
      @(negedge clk);
      req = 2'b11; we = 2'b01;
      addr = {32'h380, 32'h280}; wdata = {32'h11112222, 32'h33334444}; size = 4'b1110;
      repeat (20) @(negedge clk);
      req = 2'b00;
      repeat (2) @(negedge clk);

      // Master 1 withdraws its request during ADDR.
      mtxn(1, 1'b0, 32'h500, 32'h0, 2'b11, 1'b1);
      repeat (3) @(negedge clk);

      // Reset during the ACCESS cycle of a write.
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; addr[AW-1:0] = 32'h400; wdata[31:0] = 32'h12345678; size[1:0] = 2'b10;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!wr && n < 10);
      chk(P, "write_seen_before_reset", wr, 1);
      req[0] = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk(P, "abort_outputs", {wr, dbe, ack, busy, grant}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Random traffic from both masters.
      fork
        for (int k = 0; k < 20; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          mtxn(0, 1'($urandom), $urandom, $urandom, 2'($urandom), ($urandom_range(0, 3) == 0));
        end
        for (int k = 0; k < 20; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          mtxn(1, 1'($urandom), $urandom, $urandom, 2'($urandom), ($urandom_range(0, 3) == 0));
        end
      join
      repeat (5) @(negedge clk);

      chk(P, "m0_ack_count", got_cnt[0], exp_cnt[0]);
      chk(P, "m1_ack_count", got_cnt[1], exp_cnt[1]);
      chk(P, "queue_drained", q.size(), 0);
      done_f[P] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (done_f[0] && done_f[1]) break;
    end
    if (!(done_f[0] && done_f[1])) begin
      total++;
      bad++;
      $display("FAIL sequence_timeout: got unfinished expected finished");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
